mem_word_viewer: RTL

MEM_WORD_VIEWER -- requirements
Module: mem_word_viewer

---
 rtl/mem_viewer_pkg.sv | 37 +++
 rtl/hex_to_7seg.sv | 31 +++
 rtl/mem_word_viewer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_viewer_pkg.sv
// Shared types and constants for the memory word viewer: FSM states, widths,
// the timeout fill word and active-low {g,f,e,d,c,b,a} segment patterns.
package mem_viewer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned WADDR_W = 14;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [31:0] DEAD_WORD = 32'hDEAD_DEAD;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_7seg.sv
// One hex digit to an active-low {g,f,e,d,c,b,a} seven-segment pattern.
module hex_to_7seg
  import mem_viewer_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/mem_word_viewer.sv
// Fetches the memory word under the stepped byte address and shows half of it
// plus the low word-address byte on six digits. Define MEM_VIEWER_TIMEOUT_EN
// to abandon reads that stall in WAIT and flag err.
module mem_word_viewer
  import mem_viewer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned DATA_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address,
  input  logic               sel_high,
  output logic               rd_req,
  output logic [WADDR_W-1:0] rd_addr,
  input  logic               rd_ready,
  input  logic               rd_valid,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [SEG_W-1:0]   hex0,
  output logic [SEG_W-1:0]   hex1,
  output logic [SEG_W-1:0]   hex2,
  output logic [SEG_W-1:0]   hex3,
  output logic [SEG_W-1:0]   hex4,
  output logic [SEG_W-1:0]   hex5,
  output logic               busy,
  output logic               err
);

  localparam int unsigned HALF_W = DATA_W / 2;

  state_e             state;
  logic [WADDR_W-1:0] last_addr;
  logic               pending;
  logic [DATA_W-1:0]  data_reg;
  logic [WADDR_W-1:0] word_addr;
  logic [HALF_W-1:0]  disp_half;
  logic [1:0]         byte_off_unused;
  logic [CNT_W-1:0]   timeout_cfg_unused;

  assign word_addr          = address[ADDR_W-1:2];
  assign byte_off_unused    = address[1:0];
  assign timeout_cfg_unused = CNT_W'(TIMEOUT_CYCLES);
  assign rd_addr            = last_addr;

`ifdef MEM_VIEWER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Fetch sequencer; pending remembers any word change seen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_req    <= 1'b0;
      busy      <= 1'b0;
      last_addr <= '0;
      pending   <= 1'b1;
      data_reg  <= '0;
`ifdef MEM_VIEWER_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      if (state != ST_IDLE && word_addr != last_addr) begin
        pending <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (pending || word_addr != last_addr) begin
            state     <= ST_REQ;
            last_addr <= word_addr;
            pending   <= 1'b0;
            rd_req    <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          if (rd_ready) begin
            state  <= ST_WAIT;
            rd_req <= 1'b0;
`ifdef MEM_VIEWER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (rd_valid) begin
            data_reg <= rd_data;
            state    <= ST_CAPTURE;
`ifdef MEM_VIEWER_TIMEOUT_EN
            err_q    <= 1'b0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            data_reg <= DATA_W'(DEAD_WORD);
            err_q    <= 1'b1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        ST_CAPTURE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          rd_req <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Half select is deliberately unregistered so the toggle is immediate.
  assign disp_half = sel_high ? data_reg[DATA_W-1 -: HALF_W] : data_reg[HALF_W-1:0];

  hex_to_7seg u_hex0 (.nib(disp_half[3:0]),   .seg(hex0));
  hex_to_7seg u_hex1 (.nib(disp_half[7:4]),   .seg(hex1));
  hex_to_7seg u_hex2 (.nib(disp_half[11:8]),  .seg(hex2));
  hex_to_7seg u_hex3 (.nib(disp_half[15:12]), .seg(hex3));
  hex_to_7seg u_hex4 (.nib(last_addr[3:0]),   .seg(hex4));
  hex_to_7seg u_hex5 (.nib(last_addr[7:4]),   .seg(hex5));

endmodule
